// File: rtl/fft8_pipe.sv
`timescale 1ns/1ps
// Three-stage pipelined 8-point radix-2 DIT FFT/IFFT with a single advance
// enable; each stage register carries data, a valid bit and the mode bit.
module fft8_pipe #(
  parameter int DW  = 12,
  parameter int TWW = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_inv,
  input  logic [8*DW-1:0] in_r,
  input  logic [8*DW-1:0] in_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [8*DW-1:0] out_r,
  output logic [8*DW-1:0] out_i,
  output logic            out_inv
);
  localparam int VW = 8 * DW;
  localparam int PW = DW + TWW + 1;
  localparam logic signed [TWW-1:0] C_Q8 = TWW'(181);

  typedef logic signed [DW-1:0] smp_t;

  // (s * 1/sqrt2) with floor, wrapped back to sample width.
  function automatic smp_t mul_c(input logic signed [DW:0] s);
    logic signed [PW-1:0] prod;
    prod = PW'(s) * PW'(C_Q8);
    return smp_t'(prod >>> 8);
  endfunction

  function automatic logic [2*DW-1:0] twiddle(input logic [1:0] k, input logic inv,
                                              input smp_t xr, input smp_t xi);
    logic signed [DW:0] xe, ye, p, m, n, q;
    smp_t rr, ri;
    xe = {xr[DW-1], xr};
    ye = {xi[DW-1], xi};
    p  = xe + ye;
    m  = xe - ye;
    n  = ye - xe;
    q  = -xe - ye;
    rr = xr;
    ri = xi;
    case (k)
      2'd1: if (inv) begin rr = mul_c(m); ri = mul_c(p); end
            else     begin rr = mul_c(p); ri = mul_c(n); end
      2'd2: if (inv) begin rr = -xi; ri = xr;  end
            else     begin rr = xi;  ri = -xr; end
      2'd3: if (inv) begin rr = mul_c(q); ri = mul_c(m); end
            else     begin rr = mul_c(n); ri = mul_c(q); end
      default: ;
    endcase
    return {rr, ri};
  endfunction

  // One butterfly column; span is 1 << hl, twiddle index scales with span.
  function automatic logic [2*VW-1:0] bfly_stage(input logic [VW-1:0] vr, input logic [VW-1:0] vi,
                                                 input int hl, input logic inv);
    logic [VW-1:0] yr, yi;
    smp_t ur, ui, tr, ti;
    logic [1:0] tw;
    int h, bot;
    h  = 1 << hl;
    yr = vr;
    yi = vi;
    for (int k = 0; k < 8; k++) begin
      if ((k & h) == 0) begin
        bot = k + h;
        tw  = 2'((k & (h - 1)) << (2 - hl));
        {tr, ti} = twiddle(tw, inv, vr[bot*DW +: DW], vi[bot*DW +: DW]);
        ur = vr[k*DW +: DW];
        ui = vi[k*DW +: DW];
        yr[k*DW +: DW]   = ur + tr;
        yi[k*DW +: DW]   = ui + ti;
        yr[bot*DW +: DW] = ur - tr;
        yi[bot*DW +: DW] = ui - ti;
      end
    end
    return {yr, yi};
  endfunction

  function automatic int bitrev3(input int k);
    return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
  endfunction

  logic [VW-1:0] rev_r, rev_i, st1_r, st1_i, st2_r, st2_i, st3_r, st3_i, sc_r, sc_i;
  logic [VW-1:0] s1_r, s1_i, s2_r, s2_i;
  logic          s1_v, s1_inv, s2_v, s2_inv;
  logic          adv;

  // Handshake: a vector moves on an edge where valid & ready; the whole
  // pipeline advances only when the output slot is empty or being consumed.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  always_comb begin
    rev_r = '0;
    rev_i = '0;
    for (int k = 0; k < 8; k++) begin
      rev_r[k*DW +: DW] = in_r[bitrev3(k)*DW +: DW];
      rev_i[k*DW +: DW] = in_i[bitrev3(k)*DW +: DW];
    end
    {st1_r, st1_i} = bfly_stage(rev_r, rev_i, 0, in_inv);
    {st2_r, st2_i} = bfly_stage(s1_r, s1_i, 1, s1_inv);
    {st3_r, st3_i} = bfly_stage(s2_r, s2_i, 2, s2_inv);
  end

  // Inverse results are divided by 8 (floor) after the last column.
  always_comb begin
    smp_t tr, ti;
    sc_r = st3_r;
    sc_i = st3_i;
    for (int k = 0; k < 8; k++) begin
      tr = st3_r[k*DW +: DW];
      ti = st3_i[k*DW +: DW];
      if (s2_inv) begin
        sc_r[k*DW +: DW] = tr >>> 3;
        sc_i[k*DW +: DW] = ti >>> 3;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v      <= 1'b0;
      s1_inv    <= 1'b0;
      s1_r      <= '0;
      s1_i      <= '0;
      s2_v      <= 1'b0;
      s2_inv    <= 1'b0;
      s2_r      <= '0;
      s2_i      <= '0;
      out_valid <= 1'b0;
      out_inv   <= 1'b0;
      out_r     <= '0;
      out_i     <= '0;
    end else if (adv) begin
      s1_v      <= in_valid;
      s1_inv    <= in_inv;
      s1_r      <= st1_r;
      s1_i      <= st1_i;
      s2_v      <= s1_v;
      s2_inv    <= s1_inv;
      s2_r      <= st2_r;
      s2_i      <= st2_i;
      out_valid <= s2_v;
      out_inv   <= s2_inv;
      out_r     <= sc_r;
      out_i     <= sc_i;
    end
  end
endmodule

// File: tb/tb_fft8_pipe.sv
`timescale 1ns/1ps
// Directed bench for fft8_pipe: hand-computed vectors plus an integer
// reference transform feeding an expected queue for streaming scenarios.
module tb_fft8_pipe;
  localparam int DW = 12;
  localparam int VW = 8 * DW;

  typedef int vec8_t[8];

  logic          clk = 1'b0;
  logic          rst_n, in_valid, in_ready, in_inv, out_valid, out_ready, out_inv;
  logic [VW-1:0] in_r, in_i, out_r, out_i;

  int            total = 0;
  int            bad = 0;
  logic [VW-1:0] exp_r_q[$];
  logic [VW-1:0] exp_i_q[$];
  logic          exp_inv_q[$];

  always #5 clk = ~clk;

  fft8_pipe #(.DW(DW), .TWW(9)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv),
    .in_r(in_r), .in_i(in_i), .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_i(out_i), .out_inv(out_inv)
  );

  // ---------------- reference model ----------------
  function automatic int wrapn(input int v, input int n);
    int sh;
    sh = 32 - n;
    return (v <<< sh) >>> sh;
  endfunction

  function automatic int sx(input logic [DW-1:0] s);
    return int'(signed'(s));
  endfunction

  function automatic int mulc(input int s);
    int s13;
    s13 = wrapn(s, DW + 1);
    return wrapn((s13 * 181) >>> 8, DW);
  endfunction

  task automatic model(input logic [VW-1:0] xr, input logic [VW-1:0] xi, input logic inv,
                       output logic [VW-1:0] yr, output logic [VW-1:0] yi);
    int ar[8], ai[8], rv[8], wu[4], wv[4], wc[4];
    int w, br, bi, tr, ti, v;
    rv = '{0, 4, 2, 6, 1, 5, 3, 7};
    wu = '{1, 1, 0, -1};
    wv = '{0, -1, -1, -1};
    wc = '{0, 1, 0, 1};
    for (int k = 0; k < 8; k++) begin
      ar[k] = sx(xr[rv[k]*DW +: DW]);
      ai[k] = sx(xi[rv[k]*DW +: DW]);
    end
    for (int h = 1; h < 8; h = h * 2) begin
      for (int k = 0; k < 8; k++) begin
        if ((k & h) == 0) begin
          w  = (k % h) * (4 / h);
          br = ar[k+h];
          bi = ai[k+h];
          v  = inv ? -wv[w] : wv[w];
          tr = wu[w] * br - v * bi;
          ti = v * br + wu[w] * bi;
          if (wc[w] != 0) begin
            tr = mulc(tr);
            ti = mulc(ti);
          end else begin
            tr = wrapn(tr, DW);
            ti = wrapn(ti, DW);
          end
          ar[k+h] = wrapn(ar[k] - tr, DW);
          ai[k+h] = wrapn(ai[k] - ti, DW);
          ar[k]   = wrapn(ar[k] + tr, DW);
          ai[k]   = wrapn(ai[k] + ti, DW);
        end
      end
    end
    for (int k = 0; k < 8; k++) begin
      if (inv) begin
        ar[k] = ar[k] >>> 3;
        ai[k] = ai[k] >>> 3;
      end
      yr[k*DW +: DW] = ar[k][DW-1:0];
      yi[k*DW +: DW] = ai[k][DW-1:0];
    end
  endtask

  function automatic logic [VW-1:0] pack8(input vec8_t v);
    logic [VW-1:0] p;
    for (int k = 0; k < 8; k++) p[k*DW +: DW] = v[k][DW-1:0];
    return p;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] p;
    for (int k = 0; k < 8; k++) p[k*DW +: DW] = DW'($urandom_range(0, 4095));
    return p;
  endfunction

  // ---------------- driver ----------------
  task automatic drive_cycle(input logic v, input logic inv, input logic [VW-1:0] r,
                             input logic [VW-1:0] i, input logic ordy,
                             output logic acc, output logic fired, output logic gir,
                             output logic gov, output logic [VW-1:0] gr,
                             output logic [VW-1:0] gi, output logic ginv);
    logic [VW-1:0] yr, yi;
    @(negedge clk);
    in_valid  = v;
    in_inv    = inv;
    in_r      = r;
    in_i      = i;
    out_ready = ordy;
    #1;
    acc   = in_valid & in_ready & rst_n;
    gir   = in_ready;
    gov   = out_valid;
    fired = out_valid & out_ready;
    gr    = out_r;
    gi    = out_i;
    ginv  = out_inv;
    if (acc) begin
      model(r, i, inv, yr, yi);
      exp_r_q.push_back(yr);
      exp_i_q.push_back(yi);
      exp_inv_q.push_back(inv);
    end
    @(posedge clk);
  endtask

  task automatic run_one(input logic [VW-1:0] r, input logic [VW-1:0] i, input logic inv,
                         output logic ok, output logic [VW-1:0] gr, output logic [VW-1:0] gi,
                         output logic ginv);
    logic acc, fired, gir, gov;
    acc = 1'b0;
    fired = 1'b0;
    for (int c = 0; c < 10 && !acc; c++)
      drive_cycle(1'b1, inv, r, i, 1'b1, acc, fired, gir, gov, gr, gi, ginv);
    fired = 1'b0;
    for (int c = 0; c < 10 && !fired; c++)
      drive_cycle(1'b0, 1'b0, '0, '0, 1'b1, acc, fired, gir, gov, gr, gi, ginv);
    ok = fired;
    exp_r_q.delete();
    exp_i_q.delete();
    exp_inv_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
    total++; if (out_inv !== 1'b0) begin bad++; $display("FAIL rst_out_inv got=%b want=0", out_inv); end
    total++; if (out_r !== '0) begin bad++; $display("FAIL rst_out_r got=%h want=0", out_r); end
    total++; if (out_i !== '0) begin bad++; $display("FAIL rst_out_i got=%h want=0", out_i); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rel_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_impulse();
    logic acc, fired, gir, gov, ginv;
    logic [VW-1:0] gr, gi, xr, er;
    vec8_t ev, xv;
    xv = '{100, 0, 0, 0, 0, 0, 0, 0};
    ev = '{100, 100, 100, 100, 100, 100, 100, 100};
    xr = pack8(xv);
    er = pack8(ev);
    drive_cycle(1'b1, 1'b0, xr, '0, 1'b1, acc, fired, gir, gov, gr, gi, ginv);
    total++; if (acc !== 1'b1) begin bad++; $display("FAIL imp_first_accept got=%b want=1", acc); end
    for (int c = 1; c <= 3; c++) begin
      drive_cycle(1'b0, 1'b0, '0, '0, 1'b1, acc, fired, gir, gov, gr, gi, ginv);
      total++;
      if (gov !== (c == 3)) begin bad++; $display("FAIL imp_latency edge=%0d got=%b want=%b", c, gov, (c == 3)); end
      if (c == 3) begin
        total++; if (gr !== er) begin bad++; $display("FAIL imp_re got=%h want=%h", gr, er); end
        total++; if (gi !== '0) begin bad++; $display("FAIL imp_im got=%h want=0", gi); end
        total++; if (ginv !== 1'b0) begin bad++; $display("FAIL imp_inv got=%b want=0", ginv); end
      end
    end
    exp_r_q.delete();
    exp_i_q.delete();
    exp_inv_q.delete();
  endtask

  task automatic test_tone();
    logic ok, ginv;
    logic [VW-1:0] gr, gi, xr, er, ei;
    vec8_t xv, erv, eiv;
    xv  = '{0, 64, 0, 0, 0, 0, 0, 0};
    erv = '{64, 45, 0, -46, -64, -45, 0, 46};
    eiv = '{0, -46, -64, -46, 0, 46, 64, 46};
    xr = pack8(xv);
    er = pack8(erv);
    ei = pack8(eiv);
    run_one(xr, '0, 1'b0, ok, gr, gi, ginv);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL tone_timeout got=%b want=1", ok); end
    total++; if (gr !== er) begin bad++; $display("FAIL tone_re got=%h want=%h", gr, er); end
    total++; if (gi !== ei) begin bad++; $display("FAIL tone_im got=%h want=%h", gi, ei); end
    total++; if (ginv !== 1'b0) begin bad++; $display("FAIL tone_inv got=%b want=0", ginv); end
  endtask

  task automatic test_inverse();
    logic ok, ginv;
    logic [VW-1:0] gr, gi, xr, e100, e800;
    vec8_t xv, av, bv;
    xv = '{800, 0, 0, 0, 0, 0, 0, 0};
    av = '{100, 100, 100, 100, 100, 100, 100, 100};
    bv = '{800, 0, 0, 0, 0, 0, 0, 0};
    xr   = pack8(xv);
    e100 = pack8(av);
    e800 = pack8(bv);
    run_one(xr, '0, 1'b1, ok, gr, gi, ginv);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL inv_timeout got=%b want=1", ok); end
    total++; if (gr !== e100) begin bad++; $display("FAIL inv_re got=%h want=%h", gr, e100); end
    total++; if (gi !== '0) begin bad++; $display("FAIL inv_im got=%h want=0", gi); end
    total++; if (ginv !== 1'b1) begin bad++; $display("FAIL inv_mode got=%b want=1", ginv); end
    run_one(e100, '0, 1'b0, ok, gr, gi, ginv);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL fwd_dc_timeout got=%b want=1", ok); end
    total++; if (gr !== e800) begin bad++; $display("FAIL fwd_dc_re got=%h want=%h", gr, e800); end
    total++; if (gi !== '0) begin bad++; $display("FAIL fwd_dc_im got=%h want=0", gi); end
    total++; if (ginv !== 1'b0) begin bad++; $display("FAIL fwd_dc_mode got=%b want=0", ginv); end
  endtask

  task automatic test_backpressure();
    logic [VW-1:0] vr[4], vi[4];
    logic acc, fired, gir, gov, ginv, sinv, einv, ordy, v, seen;
    logic [VW-1:0] gr, gi, sr, si, er, ei;
    int idx, outs, stall;
    idx = 0; outs = 0; stall = 0; seen = 1'b0;
    sr = '0; si = '0; sinv = 1'b0;
    for (int k = 0; k < 4; k++) begin
      vr[k] = rand_vec();
      vi[k] = rand_vec();
    end
    for (int cyc = 0; cyc < 40 && outs < 4; cyc++) begin
      ordy = !(seen && stall < 5);
      v = (idx < 4);
      drive_cycle(v, 1'(idx % 2), vr[idx % 4], vi[idx % 4], ordy, acc, fired, gir, gov, gr, gi, ginv);
      if (acc) idx++;
      if (!ordy) begin
        total++;
        if (gir !== 1'b0 || gov !== 1'b1) begin
          bad++; $display("FAIL bp_stall_hs in_ready=%b out_valid=%b want 0,1", gir, gov);
        end
        if (stall == 0) begin
          sr = gr; si = gi; sinv = ginv;
        end else begin
          total++;
          if ({gr, gi, ginv} !== {sr, si, sinv}) begin
            bad++; $display("FAIL bp_hold got=%h_%h_%b want=%h_%h_%b", gr, gi, ginv, sr, si, sinv);
          end
        end
        stall++;
      end
      if (fired) begin
        seen = 1'b1;
        outs++;
        total++;
        if (exp_r_q.size() == 0) begin
          bad++; $display("FAIL bp_data got=%h want=none", gr);
        end else begin
          er = exp_r_q.pop_front(); ei = exp_i_q.pop_front(); einv = exp_inv_q.pop_front();
          if ({gr, gi, ginv} !== {er, ei, einv}) begin
            bad++; $display("FAIL bp_data got=%h_%h_%b want=%h_%h_%b", gr, gi, ginv, er, ei, einv);
          end
        end
      end
    end
    total++;
    if (outs != 4 || exp_r_q.size() != 0 || stall != 5) begin
      bad++; $display("FAIL bp_count outs=%0d left=%0d stalls=%0d want 4,0,5", outs, exp_r_q.size(), stall);
    end
  endtask

  task automatic test_reset_mid();
    logic acc, fired, gir, gov, ginv, einv;
    logic [VW-1:0] gr, gi, er, ei, nr, ni;
    int accepted, fires;
    accepted = 0; fires = 0;
    for (int k = 0; k < 3; k++) begin
      drive_cycle(1'b1, 1'(k % 2), rand_vec(), rand_vec(), 1'b0, acc, fired, gir, gov, gr, gi, ginv);
      if (acc) accepted++;
    end
    total++; if (accepted != 3) begin bad++; $display("FAIL rm_fill got=%0d want=3", accepted); end
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_out_valid got=%b want=0", out_valid); end
    total++; if ({out_r, out_i, out_inv} !== '0) begin bad++; $display("FAIL rm_out_zero got=%h_%h_%b want=0", out_r, out_i, out_inv); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rm_in_ready got=%b want=1", in_ready); end
    exp_r_q.delete();
    exp_i_q.delete();
    exp_inv_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    nr = rand_vec();
    ni = rand_vec();
    acc = 1'b0;
    for (int c = 0; c < 10 && !acc; c++)
      drive_cycle(1'b1, 1'b1, nr, ni, 1'b1, acc, fired, gir, gov, gr, gi, ginv);
    for (int c = 0; c < 8; c++) begin
      drive_cycle(1'b0, 1'b0, '0, '0, 1'b1, acc, fired, gir, gov, gr, gi, ginv);
      if (fired) begin
        fires++;
        total++;
        if (exp_r_q.size() == 0) begin
          bad++; $display("FAIL rm_data got=%h want=none", gr);
        end else begin
          er = exp_r_q.pop_front(); ei = exp_i_q.pop_front(); einv = exp_inv_q.pop_front();
          if ({gr, gi, ginv} !== {er, ei, einv}) begin
            bad++; $display("FAIL rm_data got=%h_%h_%b want=%h_%h_%b", gr, gi, ginv, er, ei, einv);
          end
        end
      end
    end
    total++; if (fires != 1) begin bad++; $display("FAIL rm_count got=%0d want=1", fires); end
  endtask

  task automatic test_mixed();
    logic [VW-1:0] vr[8], vi[8];
    logic acc, fired, gir, gov, ginv, einv, v;
    logic [VW-1:0] gr, gi, er, ei;
    int idx, outs, first, last;
    idx = 0; outs = 0; first = -1; last = -1;
    for (int k = 0; k < 8; k++) begin
      vr[k] = rand_vec();
      vi[k] = rand_vec();
    end
    for (int cyc = 0; cyc < 30 && outs < 8; cyc++) begin
      v = (idx < 8);
      drive_cycle(v, 1'(idx % 2), vr[idx % 8], vi[idx % 8], 1'b1, acc, fired, gir, gov, gr, gi, ginv);
      if (v) begin
        total++;
        if (acc !== 1'b1) begin bad++; $display("FAIL mix_accept idx=%0d got=%b want=1", idx, acc); end
      end
      if (acc) idx++;
      if (fired) begin
        if (first < 0) first = cyc;
        last = cyc;
        outs++;
        total++;
        if (exp_r_q.size() == 0) begin
          bad++; $display("FAIL mix_data got=%h want=none", gr);
        end else begin
          er = exp_r_q.pop_front(); ei = exp_i_q.pop_front(); einv = exp_inv_q.pop_front();
          if ({gr, gi, ginv} !== {er, ei, einv}) begin
            bad++; $display("FAIL mix_data got=%h_%h_%b want=%h_%h_%b", gr, gi, ginv, er, ei, einv);
          end
        end
      end
    end
    total++;
    if (outs != 8 || (last - first) != 7) begin
      bad++; $display("FAIL mix_rate outs=%0d span=%0d want 8,7", outs, last - first);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_inv    = 1'b0;
    in_r      = '0;
    in_i      = '0;
    out_ready = 1'b1;
    test_reset();
    test_impulse();
    test_tone();
    test_inverse();
    test_backpressure();
    test_reset_mid();
    test_mixed();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fft8_pipe.md
FFT8_PIPE -- requirements
Module: fft8_pipe

Interface
REQ-001 The block SHALL have parameter DW, default 12, meaning the two's-complement width of each real or imaginary sample.
REQ-002 The block SHALL have parameter TWW, default 9, meaning the signed twiddle width; 1/sqrt2 is the constant 181 in Q8.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: an input vector is present.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts a vector this cycle.
REQ-007 The block SHALL have port in_inv, input, 1 bit: 0 selects forward FFT, 1 selects inverse FFT; it is sampled together with the data.
REQ-008 The block SHALL have ports in_r and in_i, input, 8*DW bits each: sample k is at [k*DW +: DW], in natural order.
REQ-009 The block SHALL have port out_valid, output, 1 bit: a result vector is present.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the result.
REQ-011 The block SHALL have ports out_r and out_i, output, 8*DW bits each: bin k is at [k*DW +: DW], in natural order.
REQ-012 The block SHALL have port out_inv, output, 1 bit: the mode of the vector currently presented on out_r/out_i.

Function
REQ-013 The block SHALL compute an 8-point radix-2 DIT transform in three butterfly stages, each followed by a pipeline register holding data, a valid bit and the mode bit.
REQ-014 The block SHALL use a single pipeline advance enable: adv = ~out_valid | out_ready; in_ready = adv.
REQ-015 The block SHALL accept a vector on a rising edge where in_valid & in_ready; when adv = 1 and in_valid = 0, a bubble with valid = 0 SHALL enter stage 1.
REQ-016 The block SHALL present an accepted vector on out_valid exactly 3 rising edges after acceptance when adv stays 1, allowing back-to-back throughput of one vector per cycle.
REQ-017 The block SHALL freeze all stage registers while adv = 0, holding out_r, out_i, out_valid and out_inv stable.
REQ-018 The block SHALL apply the input bit-reversal permutation (0,4,2,6,1,5,3,7) internally.
REQ-019 The block SHALL use these twiddle factors: forward W^0 = 1, W^1 = c - jc, W^2 = -j, W^3 = -c - jc; inverse uses the complex conjugates.
REQ-020 The block SHALL implement multiplies by 1, ±j or -1 exactly, as swap or negate operations with no multiplier.
REQ-021 For multiplication by (±c ± jc), the block SHALL form the two sums and differences of the operand at DW+1 bits, then compute (s*181)>>>8 as an arithmetic shift with floor, then truncate to DW bits.
REQ-022 All butterfly outputs SHALL be DW-bit modulo (wrapping) two's-complement results, with no saturation.
REQ-023 In inverse mode, the block SHALL arithmetic-shift each stage-3 result right by 3 (divide by 8, floor) before the output register; forward mode SHALL apply no scaling.
REQ-024 Vectors of different mode SHALL be allowed in adjacent pipeline slots, and each vector SHALL use its own captured mode.
REQ-025 The block SHALL produce no combinational path from in_* to out_*; the only combinational paths SHALL be out_valid/out_ready to in_ready.

Reset
REQ-026 While rst_n = 0, all three stage valid bits, out_valid and out_inv SHALL be 0, and out_r and out_i SHALL be all-zero.
REQ-027 In-flight vectors SHALL be discarded when reset asserts mid-operation, and no partial vector SHALL ever be output.
REQ-028 in_ready SHALL be 1 during reset and in the first cycle after deassertion; acceptance SHALL begin on the first rising edge with rst_n = 1.

Verification
REQ-029 Scenario 1, forward impulse, DW = 12: x0 = 100, all other samples 0, in_inv = 0 -> after 3 cycles, every bin = 100 + j0.
REQ-030 Scenario 2, forward x1 = 64, all other samples 0 -> X0 = 64, X1 = 45 - j46, X2 = 0 - j64, X4 = -64, X5 = -45 + j46.
REQ-031 Scenario 3, inverse: X0 = 800, all other samples 0, in_inv = 1 -> every output = 100 + j0 and out_inv = 1; the same vector with in_inv = 0 -> out bin0 = 800, all other bins 0.
REQ-032 Scenario 4, backpressure: stream 4 vectors with out_ready held 0 for 5 cycles after the first out_valid -> outputs are held stable, in_ready = 0, all 4 vectors appear in order, and none is lost or duplicated.
REQ-033 Scenario 5, reset mid-operation: assert rst_n = 0 with 3 vectors in flight -> out_valid = 0 immediately; after release, only newly accepted vectors are output.
REQ-034 Scenario 6, mixed modes: alternate in_inv = 0/1 back-to-back with out_ready = 1 -> one result per cycle, each matching a bit-exact model of REQ-019 to REQ-023.
